seg_code_sequencer: RTL and testbench
=====================================

# seg_code_sequencer

Upstream feeder for the board's 7-segment symbol decoder. Produces the 6-bit symbol code (0..MAX_CODE) that the decoder turns into SEG[6:0]. Three sources move the code: a direct load from switches, a debounced-by-sync manual step button, and an auto-step prescaler, with selectable direction and wrap or stop at the bounds. Sits between the SWI/button inputs and the decoder's code input inside `top`.

## Interface
- TICK_DIV, 50_000_000: clk_2 cycles per auto step. The bench uses 4.
- MAX_CODE, 41: highest valid symbol code. Must be ≤ 63.
- clk_2  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronous to clk_2.
- load_val  in  6  code to load. Sampled directly, so it must be stable while load is held.
- load  in  1  load request, level from a switch. Acts on its rising edge.
- step  in  1  manual step button. Acts on its rising edge.
- run  in  1  auto-step enable, level.
- dir  in  1  direction: 1 = up, 0 = down.
- wrap_en  in  1  1 = wrap at bounds, 0 = stop at bounds.
- code  out  6  current symbol code, registered, goes to the decoder.
- tick  out  1  one-cycle pulse on each step-driven change of code.
- running  out  1  high in state RUN.
- done  out  1  high in state DONE.

## Operation
- **Input synchronisation.** load, step, run, dir and wrap_en each pass through a 2-FF synchronizer. The synchronized signals are suffixed _s.
- **Edge detection.** step_s and load_s feed a third register each. step_p = step_s & ~step_q, and load_p is formed the same way.
- **Prescaler.** divcnt counts 0..TICK_DIV-1 only in RUN.
  - auto_p is asserted when divcnt == TICK_DIV-1, and divcnt then returns to 0.
  - divcnt is cleared whenever the state is not RUN, and on load.
- **Step request.** adv = step_p (in IDLE or RUN) OR auto_p (in RUN).
- **Next-code rules:**
  - up, code < MAX_CODE: code+1.
  - down, code > 0: code-1.
  - up at MAX_CODE or down at 0, wrap_en_s = 1: wrap to 0 or MAX_CODE respectively, and tick = 1.
  - Same bound, wrap_en_s = 0: code holds and tick stays 0. If the request was auto_p, go to DONE. A manual step in IDLE just saturates.
- **Load.** Has priority over adv in the same cycle.
  - code <= min(load_val, MAX_CODE). No tick.
  - Out-of-range values clamp to MAX_CODE.
- **State machine** (reset state IDLE):
  - IDLE → RUN when run_s = 1.
  - RUN → IDLE when run_s = 0. This has priority over going to DONE in the same cycle.
  - RUN → DONE on a blocked auto step.
  - DONE → IDLE when run_s = 0.
  - DONE on load_p: go to RUN if run_s = 1, otherwise IDLE.
  - DONE ignores step_p and auto_p.
- **Direction change.** A dir change mid-RUN takes effect at the next adv. divcnt is not disturbed.
- **Reset values.** code = 0, tick = 0, running = 0, done = 0, state IDLE, divcnt = 0, all synchronizer and edge registers 0.
- **Reset mid-operation.** Asserting rst_n low forces all of the above immediately (asynchronous). A step edge in flight is lost.

## Timing
- **Step latency.** step rises before edge E1: step_s = 1 after E2, step_p is high during the E2-E3 cycle, code updates and tick pulses after E3. Same latency for load.
- **Run latency.** run rises before E1: state RUN and running = 1 after E3. The first auto code change lands TICK_DIV edges after that (tick after E3+TICK_DIV). Each subsequent change follows every TICK_DIV cycles.
- **tick.** Exactly one cycle wide, coincident with the new code value.
- **step_p and auto_p in the same cycle.** The code advances once, with one tick. divcnt still wraps to 0.
- **Held step.** A step held high yields one advance only. A new advance needs step to return low for at least 1 synchronized cycle.
- **Outputs.** All outputs are registered; no combinational path from inputs.

## Test plan
- **Reset:** rst_n = 0 mid-RUN at code 17 → code = 0, running = 0, done = 0, tick = 0 immediately. After release, IDLE with run = 0.
- **Manual step and clamp:**
  - load_val = 39, load edge → code 39 after 3 edges, no tick.
  - dir = 1, wrap_en = 0, three step pulses → codes 40, 41, 41; tick on the first two only; done stays 0.
  - load_val = 63 → code 41.
- **Auto wrap:** TICK_DIV = 4, code 40, dir = 1, wrap_en = 1, run = 1 → codes 41, 0, 1 every 4 cycles, a tick each time, running = 1.
- **Auto stop:** code 1, dir = 0, wrap_en = 0, run = 1 → codes 0, then DONE (done = 1, running = 0), code held at 0. A step edge causes no change. run = 0 → IDLE, done = 0.
- **Priority:**
  - load and step edges synchronized into the same cycle → code = load_val, no tick.
  - step_p coincident with auto_p at code 5, dir = 1 → code 6, single tick.
- **Direction flip:** dir 1→0 mid-RUN at code 10 → the next auto step gives 9, and the prescaler period stays 4 cycles.

Source files
------------

// File: rtl/seg_code_sequencer_if.sv
// Control/status bundle between the switch/button inputs and the symbol-code sequencer.
// The master side drives requests; the slave (sequencer) returns the code and status.
interface seg_code_sequencer_if;
    logic [5:0] load_val;
    logic       load;
    logic       step;
    logic       run;
    logic       dir;
    logic       wrap_en;
    logic [5:0] code;
    logic       tick;
    logic       running;
    logic       done;

    modport master (
        output load_val, load, step, run, dir, wrap_en,
        input  code, tick, running, done
    );

    modport slave (
        input  load_val, load, step, run, dir, wrap_en,
        output code, tick, running, done
    );
endinterface

// File: rtl/seg_code_sequencer.sv
// Symbol-code sequencer feeding the 7-segment decoder: load, manual step and
// prescaled auto-step with direction and wrap/stop handling at the code bounds.
//
// state | meaning
// IDLE  | code moves only on load or manual step
// RUN   | auto-step prescaler active, manual steps also accepted
// DONE  | auto-step hit a bound with wrap disabled; waits for run low or load
module seg_code_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_CODE = 41
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    seg_code_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [5:0]      CODE_MAX = 6'(MAX_CODE);

    logic [4:0]       sync1, sync2;
    logic             load_s, step_s, run_s, dir_s, wrap_en_s;
    logic             step_q, load_q;
    logic             step_p, load_p;
    logic [DIV_W-1:0] divcnt;
    logic             auto_p, adv, at_bound;
    state_t           state, state_nx;
    logic [5:0]       code_nx;
    logic             tick_nx;

    assign {load_s, step_s, run_s, dir_s, wrap_en_s} = sync2;
    assign step_p   = step_s & ~step_q;
    assign load_p   = load_s & ~load_q;
    assign auto_p   = (state == RUN) && (divcnt == DIV_LAST);
    assign adv      = auto_p | (step_p & (state != DONE));
    assign at_bound = dir_s ? (bus.code == CODE_MAX) : (bus.code == 6'd0);

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            step_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            sync1  <= {bus.load, bus.step, bus.run, bus.dir, bus.wrap_en};
            sync2  <= sync1;
            step_q <= step_s;
            load_q <= load_s;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n)
            divcnt <= '0;
        else if ((state != RUN) || load_p || (divcnt == DIV_LAST))
            divcnt <= '0;
        else
            divcnt <= divcnt + 1'b1;
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.code    <= 6'd0;
            bus.tick    <= 1'b0;
            bus.running <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_nx;
            bus.code    <= code_nx;
            bus.tick    <= tick_nx;
            bus.running <= (state_nx == RUN);
            bus.done    <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        code_nx  = bus.code;
        tick_nx  = 1'b0;

        // Load wins over any step request arriving in the same cycle.
        if (load_p) begin
            code_nx = (bus.load_val > CODE_MAX) ? CODE_MAX : bus.load_val;
        end else if (adv) begin
            if (!at_bound) begin
                code_nx = dir_s ? bus.code + 6'd1 : bus.code - 6'd1;
                tick_nx = 1'b1;
            end else if (wrap_en_s) begin
                code_nx = dir_s ? 6'd0 : CODE_MAX;
                tick_nx = 1'b1;
            end
        end

        case (state)
            IDLE: if (run_s) state_nx = RUN;
            RUN: begin
                if (!run_s)
                    state_nx = IDLE;
                else if (!load_p && auto_p && at_bound && !wrap_en_s)
                    state_nx = DONE;
            end
            DONE: begin
                if (load_p)
                    state_nx = run_s ? RUN : IDLE;
                else if (!run_s)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seg_code_sequencer.sv
// Directed-plus-random bench for seg_code_sequencer; expected codes come from an
// integer model of the up/down/wrap/stop rules and the documented latencies.
module tb_seg_code_sequencer;
    localparam int TICK_DIV = 4;
    localparam int MAX_CODE = 41;

    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_code = 0;

    seg_code_sequencer_if bus ();

    seg_code_sequencer #(.TICK_DIV(TICK_DIV), .MAX_CODE(MAX_CODE)) dut (
        .clk_2 (clk_2),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    // Next code for one step request; -1 means blocked at a bound without wrap.
    function automatic int nxt(input int c, input bit up, input bit wr);
        if (up) return (c < MAX_CODE) ? c + 1 : (wr ? 0 : -1);
        else    return (c > 0) ? c - 1 : (wr ? MAX_CODE : -1);
    endfunction

    function automatic int clamp(input int v);
        return (v > MAX_CODE) ? MAX_CODE : v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input bit d, input bit w);
        bus.dir     = d;
        bus.wrap_en = w;
        cyc(3);
    endtask

    task automatic do_load(input string tag, input int v);
        bus.load_val = 6'(v);
        bus.load     = 1'b1;
        cyc(2);
        chk({tag, "_pre"}, bus.code, m_code);
        cyc(1);
        m_code = clamp(v);
        chk({tag, "_code"}, bus.code, m_code);
        chk({tag, "_tick"}, bus.tick, 0);
        bus.load = 1'b0;
        cyc(3);
    endtask

    task automatic do_step(input string tag);
        int n = nxt(m_code, bus.dir, bus.wrap_en);
        bus.step = 1'b1;
        cyc(2);
        chk({tag, "_pre"}, bus.code, m_code);
        cyc(1);
        if (n >= 0) m_code = n;
        chk({tag, "_code"}, bus.code, m_code);
        chk({tag, "_tick"}, bus.tick, (n >= 0) ? 1 : 0);
        bus.step = 1'b0;
        cyc(1);
        chk({tag, "_tick_off"}, bus.tick, 0);
        chk({tag, "_done"}, bus.done, 0);
        cyc(2);
    endtask

    task automatic run_on(input string tag);
        bus.run = 1'b1;
        cyc(2);
        chk({tag, "_run_lat"}, bus.running, 0);
        cyc(1);
        chk({tag, "_running"}, bus.running, 1);
    endtask

    // Called right after an auto change (or after run_on); next change is TICK_DIV edges on.
    task automatic auto_expect(input string tag, input int n);
        cyc(TICK_DIV - 1);
        chk({tag, "_quiet"}, bus.tick, 0);
        chk({tag, "_hold"}, bus.code, m_code);
        cyc(1);
        m_code = n;
        chk({tag, "_code"}, bus.code, m_code);
        chk({tag, "_tick"}, bus.tick, 1);
        chk({tag, "_running"}, bus.running, 1);
    endtask

    task automatic run_off(input string tag);
        bus.run = 1'b0;
        cyc(3);
        chk({tag, "_running"}, bus.running, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_code"}, bus.code, m_code);
        cyc(2);
    endtask

    initial begin
        int v, n, ticks;
        bus.load_val = '0;
        bus.load     = 1'b0;
        bus.step     = 1'b0;
        bus.run      = 1'b0;
        bus.dir      = 1'b0;
        bus.wrap_en  = 1'b0;

        #12;
        chk("rst_code", bus.code, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        // Manual step and clamp
        do_load("load_rand", $urandom_range(0, MAX_CODE));
        do_load("load39", 39);
        set_mode(1, 0);
        do_step("step40");
        do_step("step41");
        do_step("step_sat");
        do_load("load63", 63);
        do_load("load_hi", $urandom_range(MAX_CODE + 1, 63));

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) do_load("rload", $urandom_range(0, 63));
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_step("rstep");
        end

        // Held step gives one advance only
        set_mode(1, 1);
        bus.step = 1'b1;
        ticks = 0;
        repeat (10) begin
            cyc(1);
            ticks += int'(bus.tick);
        end
        bus.step = 1'b0;
        m_code = nxt(m_code, 1, 1);
        chk("held_ticks", ticks, 1);
        chk("held_code", bus.code, m_code);
        cyc(3);

        // Auto wrap
        do_load("aw_load", 40);
        set_mode(1, 1);
        run_on("aw");
        auto_expect("aw41", 41);
        auto_expect("aw0", 0);
        auto_expect("aw1", 1);
        run_off("aw_off");

        // Auto stop
        do_load("as_load", 1);
        set_mode(0, 0);
        run_on("as");
        auto_expect("as0", 0);
        cyc(TICK_DIV);
        chk("as_done", bus.done, 1);
        chk("as_running", bus.running, 0);
        chk("as_code", bus.code, 0);
        chk("as_tick", bus.tick, 0);
        bus.step = 1'b1;
        cyc(4);
        chk("as_step_code", bus.code, 0);
        chk("as_step_done", bus.done, 1);
        bus.step = 1'b0;
        cyc(2);
        run_off("as_off");

        // Load and step edges in the same synchronized cycle
        set_mode(1, 1);
        v = $urandom_range(0, 63);
        if (clamp(v) == nxt(m_code, 1, 1)) v = (v + 2) % (MAX_CODE + 1);
        bus.load_val = 6'(v);
        bus.load     = 1'b1;
        bus.step     = 1'b1;
        cyc(3);
        m_code = clamp(v);
        chk("prio_code", bus.code, m_code);
        chk("prio_tick", bus.tick, 0);
        bus.load = 1'b0;
        bus.step = 1'b0;
        cyc(4);
        chk("prio_after", bus.code, m_code);

        // Step edge coincident with auto step
        do_load("co_load", 5);
        set_mode(1, 1);
        run_on("co");
        cyc(1);
        bus.step = 1'b1;
        cyc(2);
        chk("co_pre", bus.code, 5);
        cyc(1);
        m_code = 6;
        chk("co_code", bus.code, 6);
        chk("co_tick", bus.tick, 1);
        cyc(1);
        chk("co_tick_off", bus.tick, 0);
        chk("co_code_hold", bus.code, 6);
        cyc(2);
        chk("co_quiet", bus.tick, 0);
        cyc(1);
        m_code = 7;
        chk("co_period_code", bus.code, 7);
        chk("co_period_tick", bus.tick, 1);
        bus.step = 1'b0;
        run_off("co_off");

        // Direction flip mid-run
        do_load("df_load", 10);
        set_mode(1, 1);
        run_on("df");
        bus.dir = 1'b0;
        auto_expect("df9", 9);
        auto_expect("df8", 8);
        run_off("df_off");

        // Random auto runs, biased toward the bounds
        for (int r = 0; r < 4; r++) begin
            v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(MAX_CODE - 3, MAX_CODE);
            do_load("ra_load", v);
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_on("ra");
            for (int k = 0; k < 6; k++) begin
                n = nxt(m_code, bus.dir, bus.wrap_en);
                if (n < 0) begin
                    cyc(TICK_DIV);
                    chk("ra_done", bus.done, 1);
                    chk("ra_running", bus.running, 0);
                    chk("ra_code", bus.code, m_code);
                    break;
                end
                auto_expect("ra_step", n);
            end
            run_off("ra_off");
        end

        // Asynchronous reset mid-run at code 17
        do_load("rr_load", 17);
        set_mode(1, 0);
        run_on("rr");
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("rr_code", bus.code, 0);
        chk("rr_running", bus.running, 0);
        chk("rr_done", bus.done, 0);
        chk("rr_tick", bus.tick, 0);
        bus.run = 1'b0;
        m_code = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4 * TICK_DIV);
        chk("rr_idle_running", bus.running, 0);
        chk("rr_idle_code", bus.code, 0);
        chk("rr_idle_done", bus.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
